// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a 64-bit word BRAM without byte enables; sub-word stores use read-modify-write.
// Optional misalignment faulting is compiled in with LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_fault,
    output logic              mem_ld_en,
    output logic [ADDR_W-1:0] mem_ld_addr,
    input  logic [DATA_W-1:0] mem_ld_data,
    output logic              mem_st_en,
    output logic [ADDR_W-1:0] mem_st_addr,
    output logic [DATA_W-1:0] mem_st_data
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [2:0]          off_q, off_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mem_ld_en_q, mem_ld_en_d;
    logic [ADDR_W-1:0]   mem_ld_addr_q, mem_ld_addr_d;
    logic                mem_st_en_q, mem_st_en_d;
    logic [ADDR_W-1:0]   mem_st_addr_q, mem_st_addr_d;
    logic [DATA_W-1:0]   mem_st_data_q, mem_st_data_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_fault_q, resp_fault_d;

    logic                accept;
    logic [2:0]          req_lo_mask;
    logic [2:0]          req_off;
    logic                req_fault;
    logic [ADDR_W-1:0]   req_waddr;
    logic [DATA_W-1:0]   ld_shifted;
    logic [DATA_W-1:0]   ld_ext;
    logic [7:0]          size_bmask;
    logic [7:0]          bsel;
    logic [DATA_W-1:0]   wdata_shifted;
    logic [DATA_W-1:0]   merged;

    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign req_waddr   = {req_addr[ADDR_W-1:3], 3'b000};

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_fault  = resp_fault_q;
    assign mem_ld_en   = mem_ld_en_q;
    assign mem_ld_addr = mem_ld_addr_q;
    assign mem_st_en   = mem_st_en_q;
    assign mem_st_addr = mem_st_addr_q;
    assign mem_st_data = mem_st_data_q;

    // Low-address bits that must be zero for a naturally aligned access.
    always_comb begin
        req_lo_mask = 3'b000;
        case (req_size)
            2'd0:    req_lo_mask = 3'b000;
            2'd1:    req_lo_mask = 3'b001;
            2'd2:    req_lo_mask = 3'b011;
            default: req_lo_mask = 3'b111;
        endcase
`ifdef LSU_ALIGN_CHECK_EN
        req_fault = |(req_addr[2:0] & req_lo_mask);
        req_off   = req_addr[2:0];
`else
        req_fault = 1'b0;
        req_off   = req_addr[2:0] & ~req_lo_mask;
`endif
    end

    // Load lane extraction and store lane merge, both working on the CAP-cycle read word.
    always_comb begin
        ld_shifted = mem_ld_data >> {off_q, 3'b000};
        ld_ext     = ld_shifted;
        size_bmask = 8'hFF;
        case (size_q)
            2'd0: begin
                ld_ext     = {{56{signed_q & ld_shifted[7]}}, ld_shifted[7:0]};
                size_bmask = 8'h01;
            end
            2'd1: begin
                ld_ext     = {{48{signed_q & ld_shifted[15]}}, ld_shifted[15:0]};
                size_bmask = 8'h03;
            end
            2'd2: begin
                ld_ext     = {{32{signed_q & ld_shifted[31]}}, ld_shifted[31:0]};
                size_bmask = 8'h0F;
            end
            default: begin
                ld_ext     = ld_shifted;
                size_bmask = 8'hFF;
            end
        endcase
        bsel          = size_bmask << off_q;
        wdata_shifted = wdata_q << {off_q, 3'b000};
        merged        = mem_ld_data;
        for (int k = 0; k < 8; k++) begin
            if (bsel[k]) merged[8*k +: 8] = wdata_shifted[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            is_store_q    <= 1'b0;
            size_q        <= 2'd0;
            signed_q      <= 1'b0;
            off_q         <= 3'd0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            mem_ld_en_q   <= 1'b0;
            mem_ld_addr_q <= '0;
            mem_st_en_q   <= 1'b0;
            mem_st_addr_q <= '0;
            mem_st_data_q <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_store_q    <= is_store_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            off_q         <= off_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            mem_ld_en_q   <= mem_ld_en_d;
            mem_ld_addr_q <= mem_ld_addr_d;
            mem_st_en_q   <= mem_st_en_d;
            mem_st_addr_q <= mem_st_addr_d;
            mem_st_data_q <= mem_st_data_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_fault_q  <= resp_fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_fault)                state_d = S_RESP;
                    else if (!req_is_store)       state_d = S_RD;
                    else if (req_size == 2'd3)    state_d = S_WR;
                    else                          state_d = S_RD;
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = is_store_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops are loaded on the edge that enters the state they belong to,
    // so every mem_*/resp_* pin is a clean register output.
    always_comb begin
        is_store_d    = is_store_q;
        size_d        = size_q;
        signed_d      = signed_q;
        off_d         = off_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        mem_ld_en_d   = 1'b0;
        mem_ld_addr_d = mem_ld_addr_q;
        mem_st_en_d   = 1'b0;
        mem_st_addr_d = mem_st_addr_q;
        mem_st_data_d = mem_st_data_q;
        resp_valid_d  = resp_valid_q;
        resp_data_d   = resp_data_q;
        resp_fault_d  = resp_fault_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_store_d   = req_is_store;
                    size_d       = req_size;
                    signed_d     = req_signed;
                    off_d        = req_off;
                    waddr_d      = req_waddr;
                    wdata_d      = req_wdata;
                    resp_data_d  = '0;
                    resp_fault_d = req_fault;
                    if (req_fault) begin
                        resp_valid_d = 1'b1;
                    end else if (req_is_store && req_size == 2'd3) begin
                        mem_st_en_d   = 1'b1;
                        mem_st_addr_d = req_waddr;
                        mem_st_data_d = req_wdata;
                    end else begin
                        mem_ld_en_d   = 1'b1;
                        mem_ld_addr_d = req_waddr;
                    end
                end
            end
            S_CAP: begin
                if (is_store_q) begin
                    mem_st_en_d   = 1'b1;
                    mem_st_addr_d = waddr_q;
                    mem_st_data_d = merged;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = ld_ext;
                end
            end
            S_WR: begin
                resp_valid_d = 1'b1;
                resp_data_d  = '0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                    resp_fault_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural 16-word BRAM (addresses alias on bits [6:3]).
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        resp_fault;
    logic        mem_ld_en;
    logic [31:0] mem_ld_addr;
    logic [63:0] mem_ld_data = '0;
    logic        mem_st_en;
    logic [31:0] mem_st_addr;
    logic [63:0] mem_st_data;

    logic [63:0] mem [16] = '{default: 64'h0};

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_st_en) mem[mem_st_addr[6:3]] <= mem_st_data;
        if (mem_ld_en) mem_ld_data <= mem[mem_ld_addr[6:3]];
    end

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_fault(resp_fault),
        .mem_ld_en(mem_ld_en), .mem_ld_addr(mem_ld_addr), .mem_ld_data(mem_ld_data),
        .mem_st_en(mem_st_en), .mem_st_addr(mem_st_addr), .mem_st_data(mem_st_data)
    );

    // Issues one request (entered #1 after a posedge) and returns once resp_valid is seen.
    // lat counts cycles after the accept edge (1 = cycle right after it); the response is left pending.
    task automatic run_txn(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [63:0] wd,
                           output int lat, output logic [63:0] d, output logic f,
                           output int nld, output int nst, output int waitc);
        req_valid = 1'b1; req_is_store = st; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nld = 0; nst = 0;
        while (!resp_valid && lat < 20) begin
            nld += int'(mem_ld_en); nst += int'(mem_st_en);
            @(posedge clk); #1; lat++;
        end
        d = resp_data; f = resp_fault;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        vec++; if ({resp_valid, resp_fault, mem_ld_en, mem_st_en} !== 4'b0) begin
            miss++; $display("FAIL reset_ctl got %b want 0000", {resp_valid, resp_fault, mem_ld_en, mem_st_en}); end
        vec++; if ({resp_data, mem_st_data, mem_ld_addr, mem_st_addr} !== 192'b0) begin
            miss++; $display("FAIL reset_data got %h/%h/%h/%h want 0", resp_data, mem_st_data, mem_ld_addr, mem_st_addr); end
        vec++; if (req_ready !== 1'b0) begin
            miss++; $display("FAIL reset_ready_in_rst got %b want 0", req_ready); end
        rst = 1'b0; #1;
        vec++; if (req_ready !== 1'b1) begin
            miss++; $display("FAIL reset_ready_after got %b want 1", req_ready); end
    endtask

    task automatic test_store8_load8();
        int lat, nld, nst, w; logic [63:0] d; logic f;
        run_txn(1'b1, 2'd3, 1'b0, 32'h40, 64'h1122334455667788, lat, d, f, nld, nst, w);
        vec++; if (lat !== 2) begin miss++; $display("FAIL st8_latency got %0d want 2", lat); end
        vec++; if (nst !== 1 || nld !== 0) begin
            miss++; $display("FAIL st8_mem_pulses got st=%0d ld=%0d want st=1 ld=0", nst, nld); end
        vec++; if (d !== 64'h0) begin miss++; $display("FAIL st8_resp_data got %h want 0", d); end
        finish_resp();
        vec++; if (mem[8] !== 64'h1122334455667788) begin
            miss++; $display("FAIL st8_mem got %h want 1122334455667788", mem[8]); end
        run_txn(1'b0, 2'd3, 1'b0, 32'h40, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (lat !== 3) begin miss++; $display("FAIL ld8_latency got %0d want 3", lat); end
        vec++; if (nld !== 1 || nst !== 0) begin
            miss++; $display("FAIL ld8_mem_pulses got ld=%0d st=%0d want ld=1 st=0", nld, nst); end
        vec++; if (d !== 64'h1122334455667788) begin
            miss++; $display("FAIL ld8_data got %h want 1122334455667788", d); end
        finish_resp();
    endtask

    task automatic test_subword_store();
        int lat, nld, nst, w; logic [63:0] d; logic f;
        run_txn(1'b1, 2'd0, 1'b0, 32'h43, 64'h00000000000000AB, lat, d, f, nld, nst, w);
        vec++; if (lat !== 4) begin miss++; $display("FAIL st1_latency got %0d want 4", lat); end
        vec++; if (nld !== 1 || nst !== 1) begin
            miss++; $display("FAIL st1_mem_pulses got ld=%0d st=%0d want 1/1", nld, nst); end
        finish_resp();
        vec++; if (mem[8] !== 64'h11223344AB667788) begin
            miss++; $display("FAIL st1_mem got %h want 11223344ab667788", mem[8]); end
        // Upper garbage in wdata must not leak into neighbouring lanes.
        run_txn(1'b1, 2'd1, 1'b0, 32'h44, 64'hFFFF00001234BEEF, lat, d, f, nld, nst, w);
        finish_resp();
        vec++; if (mem[8] !== 64'h1122BEEFAB667788) begin
            miss++; $display("FAIL st2_mem got %h want 1122beefab667788", mem[8]); end
    endtask

    task automatic test_loads_ext();
        int lat, nld, nst, w; logic [63:0] d; logic f;
        run_txn(1'b0, 2'd0, 1'b1, 32'h43, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (d !== 64'hFFFFFFFFFFFFFFAB) begin
            miss++; $display("FAIL ld1_signed got %h want ffffffffffffffab", d); end
        finish_resp();
        run_txn(1'b0, 2'd0, 1'b0, 32'h43, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (d !== 64'h00000000000000AB) begin
            miss++; $display("FAIL ld1_unsigned got %h want ab", d); end
        finish_resp();
        run_txn(1'b0, 2'd1, 1'b1, 32'h46, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (d !== 64'h0000000000001122) begin
            miss++; $display("FAIL ld2_signed got %h want 1122", d); end
        finish_resp();
        run_txn(1'b0, 2'd2, 1'b1, 32'h40, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (d !== 64'hFFFFFFFFAB667788) begin
            miss++; $display("FAIL ld4_signed_neg got %h want ffffffffab667788", d); end
        finish_resp();
        run_txn(1'b0, 2'd2, 1'b1, 32'h44, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (d !== 64'h000000001122BEEF) begin
            miss++; $display("FAIL ld4_signed_pos got %h want 1122beef", d); end
        finish_resp();
    endtask

    task automatic test_misaligned();
        int lat, nld, nst, w; logic [63:0] d; logic f;
        run_txn(1'b0, 2'd2, 1'b0, 32'h42, 64'h0, lat, d, f, nld, nst, w);
`ifdef LSU_ALIGN_CHECK_EN
        vec++; if (lat !== 1) begin miss++; $display("FAIL mis_latency got %0d want 1", lat); end
        vec++; if (f !== 1'b1 || d !== 64'h0) begin
            miss++; $display("FAIL mis_fault got f=%b d=%h want f=1 d=0", f, d); end
        vec++; if (nld !== 0 || nst !== 0) begin
            miss++; $display("FAIL mis_no_mem got ld=%0d st=%0d want 0/0", nld, nst); end
`else
        vec++; if (lat !== 3) begin miss++; $display("FAIL mis_latency got %0d want 3", lat); end
        vec++; if (f !== 1'b0 || d !== 64'h00000000AB667788) begin
            miss++; $display("FAIL mis_masked got f=%b d=%h want f=0 d=ab667788", f, d); end
`endif
        finish_resp();
    endtask

    task automatic test_backpressure();
        int lat, nld, nst, w; logic [63:0] d; logic f;
        int unstable;
        resp_ready = 1'b0;
        run_txn(1'b0, 2'd3, 1'b0, 32'h40, 64'h0, lat, d, f, nld, nst, w);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_data !== 64'h1122BEEFAB667788 || req_ready !== 1'b0)
                unstable++;
        end
        vec++; if (unstable !== 0) begin
            miss++; $display("FAIL bp_hold got %0d unstable cycles want 0", unstable); end
        finish_resp();
        vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miss++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        run_txn(1'b0, 2'd0, 1'b0, 32'h47, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (w !== 0 || d !== 64'h11) begin
            miss++; $display("FAIL bp_next got wait=%0d d=%h want 0/11", w, d); end
        finish_resp();
    endtask

    task automatic test_reset_mid_rmw();
        int lat, nld, nst, w, st_seen; logic [63:0] d; logic f;
        req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 64'h0;
        w = 0;
        while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        st_seen = int'(mem_st_en);
        rst = 1'b1; #1;
        vec++; if ({resp_valid, mem_ld_en, mem_st_en, req_ready} !== 4'b0 || mem_st_data !== 64'h0) begin
            miss++; $display("FAIL rst_mid_outputs got v=%b ld=%b st=%b rdy=%b sd=%h want 0",
                             resp_valid, mem_ld_en, mem_st_en, req_ready, mem_st_data); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; st_seen += int'(mem_st_en);
        end
        rst = 1'b0; #1;
        vec++; if (st_seen !== 0 || mem[8] !== 64'h1122BEEFAB667788) begin
            miss++; $display("FAIL rst_mid_mem got st=%0d mem=%h want 0/1122beefab667788", st_seen, mem[8]); end
        run_txn(1'b0, 2'd3, 1'b0, 32'h40, 64'h0, lat, d, f, nld, nst, w);
        vec++; if (d !== 64'h1122BEEFAB667788 || lat !== 3) begin
            miss++; $display("FAIL rst_mid_reload got %h lat=%0d want 1122beefab667788/3", d, lat); end
        finish_resp();
    endtask

    initial begin
        test_reset();
        test_store8_load8();
        test_subword_store();
        test_loads_ext();
        test_misaligned();
        test_backpressure();
        test_reset_mid_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
